// File: rtl/instr_fetch_queue_if.sv
// Fetch-side handshake bundle: PC request/stall, instruction-memory port and decode port.
// master is the fetch queue's view, slave is the surrounding core/memory view.
interface instr_fetch_queue_if;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus_4;
  logic        dec_ready;

  modport master (
    input  fetch_pc, fetch_valid, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
    output fetch_stall, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus_4
  );

  modport slave (
    output fetch_pc, fetch_valid, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
    input  fetch_stall, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus_4
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch queue: issues PC reads, pairs returned words with their PC,
// and hands them to decode; a flush kills queued entries and drops in-flight responses.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_fetch_queue_if.master    bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   protocol_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, fill_ptr, rd_ptr, drop_cnt;
  logic [PW-1:0] alloc_cnt, unfilled;
  logic [PW:0]   inflight, drop_flush;
  logic [AW-1:0] wr_idx, fill_idx, rd_idx;
  logic [DEPTH-1:0] filled;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic req, grant, pop, dec_valid;
  logic rsp_drop, rsp_fill, rsp_err;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign fill_idx = fill_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];

  // Issue, response classification and drain qualification
  always_comb begin
    alloc_cnt = wr_ptr - rd_ptr;
    unfilled  = wr_ptr - fill_ptr;
    inflight  = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    req       = bus.fetch_valid & ~bus.flush & (inflight < (PW+1)'(DEPTH));
    grant     = req & bus.imem_gnt;
    rsp_drop  = bus.imem_rvalid & (drop_cnt != '0);
    rsp_fill  = bus.imem_rvalid & (drop_cnt == '0) & (unfilled != '0);
    rsp_err   = bus.imem_rvalid & (drop_cnt == '0) & (unfilled == '0);
    dec_valid = (alloc_cnt != '0) & filled[rd_idx] & ~bus.flush;
    pop       = dec_valid & bus.dec_ready;
  end

  // Stale responses still owed after a flush; a response arriving in the flush cycle is consumed
  always_comb begin
    drop_flush = {1'b0, drop_cnt} + {1'b0, unfilled};
    if (bus.imem_rvalid && (drop_flush != '0)) begin
      drop_flush = drop_flush - (PW+1)'(1);
    end
    if (drop_flush > (PW+1)'(DEPTH)) begin
      drop_flush = (PW+1)'(DEPTH);
    end
  end

  assign bus.imem_req      = req;
  assign bus.imem_addr     = {bus.fetch_pc[31:2], 2'b00};
  assign bus.fetch_stall   = bus.fetch_valid & ~grant;
  assign bus.dec_valid     = dec_valid;
  assign bus.dec_instr     = instr_mem[rd_idx];
  assign bus.dec_pc        = pc_mem[rd_idx];
  assign bus.dec_pc_plus_4 = pc_mem[rd_idx] + 32'd4;
  assign occupancy         = alloc_cnt;

  // Pointers, fill flags, drop counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      drop_cnt     <= '0;
      filled       <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (rsp_err) begin
        protocol_err <= 1'b1;
      end
      if (bus.flush) begin
        rd_ptr   <= wr_ptr;
        fill_ptr <= wr_ptr;
        filled   <= '0;
        drop_cnt <= PW'(drop_flush);
      end else begin
        if (grant) begin
          wr_ptr         <= wr_ptr + PW'(1);
          filled[wr_idx] <= 1'b0;
        end
        if (rsp_fill) begin
          fill_ptr         <= fill_ptr + PW'(1);
          filled[fill_idx] <= 1'b1;
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // Payload storage needs no reset; it is qualified by the fill flags
  always_ff @(posedge clk) begin
    if (grant) begin
      pc_mem[wr_idx] <= bus.fetch_pc;
    end
    if (rsp_fill && !bus.flush) begin
      instr_mem[fill_idx] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: in-order memory model with programmable latency,
// expected {pc, instr} pushed on grant and compared on every decode pop.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] occupancy;
  logic          protocol_err;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .occupancy    (occupancy),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } mem_rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; int gcyc; } exp_t;

  mem_rsp_t mem_q [$];
  exp_t     exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int lat      = 1;
  logic gnt_en  = 1'b1;
  logic spur    = 1'b0;
  logic lat_chk = 1'b0;

  logic          s_req, s_stall, s_dv, s_gnt, s_perr;
  logic [PW-1:0] s_occ;
  logic [31:0]   last_pc4;
  logic [31:0]   gnt_pc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: entered just after a falling edge with stimulus already applied
  task automatic step();
    exp_t e;
    if (spur) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_BAD0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_q[0].data;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    bus.imem_gnt = gnt_en;
    #1;
    s_req   = bus.imem_req;
    s_stall = bus.fetch_stall;
    s_dv    = bus.dec_valid;
    s_gnt   = bus.imem_req & bus.imem_gnt;
    s_occ   = occupancy;
    s_perr  = protocol_err;
    if (rst_n) begin
      if (bus.dec_valid && bus.dec_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("dec_pc", bus.dec_pc, e.pc);
          check("dec_instr", bus.dec_instr, e.instr);
          check("dec_pc_plus_4", bus.dec_pc_plus_4, e.pc + 32'd4);
          if (lat_chk) check("latency", 32'(cyc - e.gcyc), 32'd2);
          last_pc4 = bus.dec_pc_plus_4;
        end
      end
      if (bus.flush) exp_q.delete();
      if (s_gnt) begin
        check("imem_addr", bus.imem_addr, {bus.fetch_pc[31:2], 2'b00});
        mem_q.push_back('{data: mem_word(bus.fetch_pc), due: cyc + lat});
        exp_q.push_back('{pc: bus.fetch_pc, instr: mem_word(bus.fetch_pc), gcyc: cyc});
        gnt_pc = bus.fetch_pc;
      end
    end
    if (bus.imem_rvalid && !spur && mem_q.size() > 0) void'(mem_q.pop_front());
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bus.fetch_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0) return;
      step();
    end
    check("drain_timeout", 32'(exp_q.size() + mem_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    logic        seen;
    rst_n           = 1'b0;
    bus.fetch_pc    = 32'h0;
    bus.fetch_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.dec_ready   = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // Reset state and issue equation with empty counts
    step();
    check("rst_occupancy", 32'(s_occ), 32'd0);
    check("rst_dec_valid", 32'(s_dv), 32'd0);
    check("rst_protocol_err", 32'(s_perr), 32'd0);
    gnt_en = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h0;
    step();
    check("rst_imem_req", 32'(s_req), 32'd1);
    check("rst_stall_nogrant", 32'(s_stall), 32'd1);
    gnt_en = 1'b1;

    // Streaming at zero wait, decode always ready
    lat = 1;
    lat_chk = 1'b1;
    bus.dec_ready = 1'b1;
    pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc = pc;
      step();
      check("stream_stall", 32'(s_stall), 32'd0);
      if (s_gnt) pc += 32'd4;
    end
    drain();
    lat_chk = 1'b0;

    // Full queue: allocation stops at DEPTH, then drains in order and resumes
    bus.dec_ready = 1'b0;
    pc = 32'h100;
    for (int i = 0; i < 6; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc = pc;
      step();
      if (i >= 4) check("full_stall", 32'(s_stall), 32'd1);
      if (s_gnt) pc += 32'd4;
    end
    check("full_occupancy", 32'(s_occ), 32'd4);
    bus.dec_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc = pc;
      step();
      if (s_gnt && !seen) begin
        check("resume_pc", gnt_pc, 32'h110);
        seen = 1'b1;
      end
      if (s_gnt) pc += 32'd4;
    end
    check("resume_seen", 32'(seen), 32'd1);
    drain();

    // Flush with two responses in flight
    lat = 3;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h20;
    step();
    bus.fetch_pc = 32'h24;
    step();
    bus.fetch_valid = 1'b0;
    bus.flush = 1'b1;
    step();
    check("flush_dv_F", 32'(s_dv), 32'd0);
    check("flush_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    bus.flush = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h400;
    step();
    check("flush_dv_F1", 32'(s_dv), 32'd0);
    check("flush_issue_F1", 32'(s_gnt), 32'd1);
    last_pc4 = 32'hFFFF_FFFF;
    drain();
    check("flush_pc_plus_4", last_pc4, 32'h404);

    // Flush coincident with the only outstanding response
    lat = 2;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h40;
    step();
    bus.fetch_valid = 1'b0;
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_rv_drop_cnt", 32'(dut.drop_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush_rv_dv", 32'(s_dv), 32'd0);
    end
    check("flush_rv_occ", 32'(s_occ), 32'd0);
    check("flush_rv_perr", 32'(s_perr), 32'd0);

    // Grant withheld for three cycles
    lat = 1;
    gnt_en = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nognt_stall", 32'(s_stall), 32'd1);
    end
    gnt_en = 1'b1;
    step();
    check("nognt_occ", 32'(s_occ), 32'd0);
    check("nognt_then_grant", 32'(s_gnt), 32'd1);
    drain();

    // Spurious response with nothing outstanding
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    check("spur_perr", 32'(s_perr), 32'd1);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h800;
    step();
    drain();
    step();
    check("spur_perr_sticky", 32'(s_perr), 32'd1);

    // PC wraps across 2^32
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'hFFFF_FFFC;
    step();
    last_pc4 = 32'hDEAD_DEAD;
    drain();
    check("wrap_pc_plus_4", last_pc4, 32'h0);

    // Reset with three entries queued
    bus.dec_ready = 1'b0;
    pc = 32'h600;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc = pc;
      step();
      if (s_gnt) pc += 32'd4;
    end
    bus.fetch_valid = 1'b0;
    step();
    step();
    check("pre_rst_occ", 32'(s_occ), 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    mem_q.delete();
    bus.dec_ready = 1'b1;
    step();
    check("mid_rst_occ", 32'(s_occ), 32'd0);
    check("mid_rst_dv", 32'(s_dv), 32'd0);
    check("mid_rst_perr", 32'(s_perr), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end that consumes the program counter stream and delivers fetched instructions to decode. Each cycle it takes the current fetch PC, issues an in-order read to instruction memory, and pairs each returned word with its PC in a DEPTH-entry queue. Decode drains the queue through a valid/ready handshake. When the block cannot accept a fetch it raises `fetch_stall`, which the PC block uses to hold its current value. A branch or jump redirect flushes the queue and discards responses already in flight.

## Interface
- `DEPTH`, default 4: number of queue entries, a power of two ≥ 2. It also bounds the total number of outstanding memory reads.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `fetch_pc` in 32: fetch address from the PC block.
- `fetch_valid` in 1: `fetch_pc` is a valid fetch request this cycle.
- `fetch_stall` out 1: the fetch was not accepted this cycle, so the PC must hold.
- `flush` in 1: redirect (branch taken or jump). Kills all queued and in-flight instructions.
- `imem_req` out 1: read request to instruction memory.
- `imem_addr` out 32: read address, equal to `{fetch_pc[31:2],2'b00}`.
- `imem_gnt` in 1: memory accepts the request. A request is issued when `imem_req & imem_gnt`.
- `imem_rvalid` in 1: a read response is present. Responses return in order, at the earliest one cycle after grant.
- `imem_rdata` in 32: read data.
- `dec_valid` out 1: the head entry is filled and available.
- `dec_instr` out 32: instruction word of the head entry.
- `dec_pc` out 32: PC of the head entry.
- `dec_pc_plus_4` out 32: `dec_pc + 4`, modulo 2^32.
- `dec_ready` in 1: decode accepts the head entry. A pop occurs when `dec_valid & dec_ready`.
- `occupancy` out $clog2(DEPTH)+1: number of allocated queue entries.
- `protocol_err` out 1: sticky flag, set by an unexpected `imem_rvalid`.

## Operation
- **Storage.** The queue holds DEPTH entries, each {pc[31:0], instr[31:0], filled}. It is managed by three pointers:
  - `wr_ptr`: allocate on grant.
  - `fill_ptr`: next entry awaiting data.
  - `rd_ptr`: head.
  - Each pointer is $clog2(DEPTH)+1 bits wide and wraps naturally.
- **Derived counts.**
  - `alloc_cnt = wr_ptr - rd_ptr`.
  - `unfilled = wr_ptr - fill_ptr`.
  - `drop_cnt` counts stale responses still owed by memory. It saturates at DEPTH.
- **Issue.**
  - `imem_req = fetch_valid & !flush & (alloc_cnt + drop_cnt < DEPTH)`. This is combinational.
  - `fetch_stall = fetch_valid & !(imem_req & imem_gnt)`.
  - On grant: write `{fetch_pc, filled=0}` at `wr_ptr`, then `wr_ptr++`.
- **Response.**
  - On `imem_rvalid` with `drop_cnt>0`: discard the data and decrement `drop_cnt`.
  - Otherwise, if `unfilled>0`: write `imem_rdata` at `fill_ptr`, set `filled`, then `fill_ptr++`.
  - Otherwise the response is unexpected: set `protocol_err` and discard the data.
- **Drain.**
  - `dec_valid = (alloc_cnt>0) & entry[rd_ptr].filled & !flush`.
  - The `dec_*` fields are read combinationally from the entry at `rd_ptr`.
  - On a pop, `rd_ptr++`.
- **Flush.**
  - At the next edge: `rd_ptr`, `fill_ptr` and `wr_ptr` all take the value of `wr_ptr`, and all `filled` bits clear.
  - `drop_cnt_next = drop_cnt + unfilled - (imem_rvalid ? 1 : 0)`.
  - No pop and no issue happen in the flush cycle.
- **Simultaneous events.**
  - Grant + pop + fill in the same cycle: all three apply independently.
  - Flush + `imem_rvalid`: the response is counted as consumed per the formula above and is never delivered.
  - A pop of a full queue frees a slot only at the next edge. There is no same-cycle pass-through.
- **Reset.**
  - All pointers and `drop_cnt` go to 0, all `filled` bits to 0, and `protocol_err` to 0.
  - Outputs: `dec_valid=0`, `occupancy=0`, `imem_req` follows the issue equation with empty counts.
  - The `dec_instr`, `dec_pc` and `dec_pc_plus_4` values are don't-care while `dec_valid=0`.
  - Reset mid-operation abandons outstanding responses without tracking them. The memory is reset with the core.

## Timing
- Fetch-to-decode latency with zero-wait memory: grant in cycle N, `rvalid` in N+1, `dec_valid` in N+2 (the fill is registered).
- Sustained throughput is one instruction per cycle when `DEPTH ≥ 3` and decode is always ready.
- `fetch_stall` is combinational from `fetch_valid`, `flush`, `imem_gnt` and the registered counts. It must be ready before the PC register's edge in the same cycle.
- A flush in cycle F:
  - `dec_valid=0` in F and in F+1.
  - The first post-redirect fetch may issue in F+1.

## Test plan
- **Streaming.** Zero-wait memory, `dec_ready=1`, PC stepping 0x0, 0x4, 0x8, 0xC → decode sees the same four PCs with matching rdata, each 2 cycles after its grant, with `fetch_stall` never asserted.
- **Full queue.** `DEPTH=4`, `dec_ready=0`, six fetches from 0x100 → `occupancy` reaches 4 and `fetch_stall=1` from the 5th fetch. Raising `dec_ready` then drains 0x100, 0x104, 0x108, 0x10C in order, and fetching resumes at 0x110.
- **Flush with responses in flight.** Memory delays responses by 3 cycles; issue to 0x20 and 0x24, then flush the cycle after the second grant → `drop_cnt=2`. Both returned words are discarded. Fetch 0x400 → decode sees only 0x400, with `dec_pc_plus_4=0x404`.
- **Flush coincident with `rvalid`.** One entry unfilled → `drop_cnt_next=0` and nothing is delivered.
- **Backpressure and errors.**
  - Holding `imem_gnt=0` for 3 cycles → `fetch_stall=1` for those 3 cycles, with no allocation.
  - A spurious `imem_rvalid` with the queue empty → `protocol_err=1`, which stays set until reset.
- **Reset and wrap.**
  - Assert `rst_n=0` with 3 entries queued → the next cycle shows `occupancy=0`, `dec_valid=0`.
  - PC 0xFFFFFFFC → `dec_pc_plus_4=0x00000000`.
